// File: rtl/sw_debounce_if.sv
// Switch conditioning bus: raw board levels in, debounced levels and edge strobes out.
interface sw_debounce_if #(
   parameter int n_sw = 9
);
   logic [n_sw-1:0] sw_raw;
   logic [n_sw-1:0] sw_clean;
   logic [n_sw-1:0] sw_rise;
   logic [n_sw-1:0] sw_fall;
   logic            sw_changed;

   modport master (
      output sw_raw,
      input  sw_clean,
      input  sw_rise,
      input  sw_fall,
      input  sw_changed
   );

   modport slave (
      input  sw_raw,
      output sw_clean,
      output sw_rise,
      output sw_fall,
      output sw_changed
   );
endinterface

// File: rtl/sw_debounce.sv
// Per-bit synchronise and debounce of the board switches feeding the CPU switch path,
// with one-cycle rise/fall strobes and a combined change flag.
module sw_debounce #(
   parameter int n_sw            = 9,
   parameter int cnt_w           = 16,
   parameter int debounce_cycles = 50000
) (
   input logic          clk,
   input logic          n_reset,
   sw_debounce_if.slave bus
);
   localparam logic [cnt_w-1:0] cnt_tc = cnt_w'(debounce_cycles - 1);

   logic [n_sw-1:0]  sync1;
   logic [n_sw-1:0]  sync2;
   logic [cnt_w-1:0] cnt [n_sw];
   logic [n_sw-1:0]  clean_q;
   logic [n_sw-1:0]  rise_q;
   logic [n_sw-1:0]  fall_q;
   logic             changed_q;
   logic [n_sw-1:0]  upd;

   // A bit is accepted when it has disagreed with the clean level for debounce_cycles edges.
   always_comb begin
      upd = '0;
      for (int i = 0; i < n_sw; i++) begin
         upd[i] = (sync2[i] != clean_q[i]) && (cnt[i] == cnt_tc);
      end
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         sync1     <= '0;
         sync2     <= '0;
         clean_q   <= '0;
         rise_q    <= '0;
         fall_q    <= '0;
         changed_q <= 1'b0;
         for (int i = 0; i < n_sw; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         sync1     <= bus.sw_raw;
         sync2     <= sync1;
         clean_q   <= clean_q ^ upd;
         rise_q    <= upd & sync2;
         fall_q    <= upd & ~sync2;
         changed_q <= |upd;
         // Terminal compare comes before the increment, so cnt never exceeds cnt_tc.
         for (int i = 0; i < n_sw; i++) begin
            if ((sync2[i] == clean_q[i]) || upd[i]) begin
               cnt[i] <= '0;
            end else begin
               cnt[i] <= cnt[i] + 1'b1;
            end
         end
      end
   end

   assign bus.sw_clean   = clean_q;
   assign bus.sw_rise    = rise_q;
   assign bus.sw_fall    = fall_q;
   assign bus.sw_changed = changed_q;
endmodule

// File: tb/tb_sw_debounce.sv
// Directed bench for sw_debounce with debounce_cycles = 4, cnt_w = 3 (update lands 6 edges after capture).
module tb_sw_debounce;
   logic clk;
   logic n_reset;
   int   checks;
   int   errors;

   sw_debounce_if #(.n_sw(9)) bus ();

   sw_debounce #(
      .n_sw           (9),
      .cnt_w          (3),
      .debounce_cycles(4)
   ) dut (
      .clk    (clk),
      .n_reset(n_reset),
      .bus    (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [8:0] raw;
      int         n;
      logic [8:0] clean;
      logic [8:0] rise;
      logic [8:0] fall;
      logic       chg;
   } vec_t;

   vec_t tbl [$];

   task automatic add_vec(input logic [8:0] raw, input int n, input logic [8:0] clean,
                          input logic [8:0] rise, input logic [8:0] fall, input logic chg);
      vec_t v;
      v.raw = raw; v.n = n; v.clean = clean; v.rise = rise; v.fall = fall; v.chg = chg;
      tbl.push_back(v);
   endtask

   task automatic check_out(input string name, input logic [8:0] e_clean, input logic [8:0] e_rise,
                            input logic [8:0] e_fall, input logic e_chg);
      checks++;
      if (bus.sw_clean !== e_clean || bus.sw_rise !== e_rise ||
          bus.sw_fall !== e_fall || bus.sw_changed !== e_chg) begin
         errors++;
         $display("FAIL %s t=%0t: got clean=%h rise=%h fall=%h chg=%b, want clean=%h rise=%h fall=%h chg=%b",
                  name, $time, bus.sw_clean, bus.sw_rise, bus.sw_fall, bus.sw_changed,
                  e_clean, e_rise, e_fall, e_chg);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks = 0;
      errors = 0;

      // Reset with all switches high
      n_reset    = 1'b0;
      bus.sw_raw = 9'h1FF;
      #2;
      check_out("reset_async", 9'h000, 9'h000, 9'h000, 1'b0);
      repeat (3) tick();
      check_out("reset_held", 9'h000, 9'h000, 9'h000, 1'b0);
      n_reset = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         tick();
         check_out("post_reset_wait", 9'h000, 9'h000, 9'h000, 1'b0);
      end
      tick();
      check_out("post_reset_rise", 9'h1FF, 9'h1FF, 9'h000, 1'b1);
      tick();
      check_out("post_reset_quiet", 9'h1FF, 9'h000, 9'h000, 1'b0);

      // Return everything to 0
      add_vec(9'h000, 5, 9'h1FF, 9'h000, 9'h000, 1'b0);
      add_vec(9'h000, 1, 9'h000, 9'h000, 9'h1FF, 1'b1);
      add_vec(9'h000, 3, 9'h000, 9'h000, 9'h000, 1'b0);
      // Clean rise on bit 0
      add_vec(9'h001, 5, 9'h000, 9'h000, 9'h000, 1'b0);
      add_vec(9'h001, 1, 9'h001, 9'h001, 9'h000, 1'b1);
      add_vec(9'h001, 2, 9'h001, 9'h000, 9'h000, 1'b0);
      // Bounce on bit 3: 3 high, 1 low, then held high
      add_vec(9'h009, 3, 9'h001, 9'h000, 9'h000, 1'b0);
      add_vec(9'h001, 1, 9'h001, 9'h000, 9'h000, 1'b0);
      add_vec(9'h009, 5, 9'h001, 9'h000, 9'h000, 1'b0);
      add_vec(9'h009, 1, 9'h009, 9'h008, 9'h000, 1'b1);
      add_vec(9'h009, 2, 9'h009, 9'h000, 9'h000, 1'b0);
      // Bits 1 and 5 up, then both dropped together
      add_vec(9'h02B, 5, 9'h009, 9'h000, 9'h000, 1'b0);
      add_vec(9'h02B, 1, 9'h02B, 9'h022, 9'h000, 1'b1);
      add_vec(9'h02B, 2, 9'h02B, 9'h000, 9'h000, 1'b0);
      add_vec(9'h009, 5, 9'h02B, 9'h000, 9'h000, 1'b0);
      add_vec(9'h009, 1, 9'h009, 9'h000, 9'h022, 1'b1);
      add_vec(9'h009, 2, 9'h009, 9'h000, 9'h000, 1'b0);
      // Mixed rise/fall, then sustained 0AA
      add_vec(9'h0AA, 5, 9'h009, 9'h000, 9'h000, 1'b0);
      add_vec(9'h0AA, 1, 9'h0AA, 9'h0A2, 9'h001, 1'b1);
      add_vec(9'h0AA, 100, 9'h0AA, 9'h000, 9'h000, 1'b0);

      for (int v = 0; v < tbl.size(); v++) begin
         for (int c = 0; c < tbl[v].n; c++) begin
            bus.sw_raw = tbl[v].raw;
            tick();
            check_out($sformatf("vec%0d_cyc%0d", v, c), tbl[v].clean, tbl[v].rise,
                      tbl[v].fall, tbl[v].chg);
         end
      end

      // Reset while bit 2 is mid-count (cnt[2] = 2 after edge 4)
      bus.sw_raw = 9'h0AE;
      repeat (4) tick();
      check_out("mid_count", 9'h0AA, 9'h000, 9'h000, 1'b0);
      #2;
      n_reset = 1'b0;
      #1;
      check_out("mid_reset_async", 9'h000, 9'h000, 9'h000, 1'b0);
      repeat (2) tick();
      check_out("mid_reset_held", 9'h000, 9'h000, 9'h000, 1'b0);
      n_reset = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         tick();
         check_out("restart_wait", 9'h000, 9'h000, 9'h000, 1'b0);
      end
      tick();
      check_out("restart_rise", 9'h0AE, 9'h0AE, 9'h000, 1'b1);
      tick();
      check_out("restart_quiet", 9'h0AE, 9'h000, 9'h000, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
